div_unit: RTL and testbench

//  Parametrised multi-cycle restoring divider for the EX stage, next to the HILO path.
//  EX issues a div/divu and holds start_i while the pipeline is stalled; the block

---
 rtl/div_unit.sv | 156 +++++++++++++++
 tb/tb_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for the EX stage (div/divu).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   signed_div_i   1 = signed divide, 0 = unsigned; sampled with start_i
//   opdata1_i      dividend, sampled with start_i
//   opdata2_i      divisor, sampled with start_i
//   start_i        request, held until ready_o is seen, then dropped
//   annul_i        abort the in-flight division (pipeline flush)
//   result_o       {remainder, quotient}, valid while ready_o is high
//   ready_o        result valid
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_FREE,
        S_BYZERO,
        S_ON,
        S_END
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;     // holds the dividend, shifted out as quotient bits shift in
    logic [WIDTH-1:0]   dsr_q, dsr_d;
    logic               neg_quo_q, neg_quo_d;
    logic               neg_rem_q, neg_rem_d;
    logic               ready_d;
    logic [2*WIDTH-1:0] result_d;
    logic [WIDTH:0]     trial;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return (~v) + WIDTH'(1);
    endfunction

    // Trial subtraction on the shifted partial remainder; MSB set means borrow.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        ready_d   = ready_o;
        result_d  = result_o;

        case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = S_BYZERO;
                    end else begin
                        state_d   = S_ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        // Divide magnitudes; signs are restored on completion.
                        quo_d     = (signed_div_i && opdata1_i[WIDTH-1]) ? negate(opdata1_i) : opdata1_i;
                        dsr_d     = (signed_div_i && opdata2_i[WIDTH-1]) ? negate(opdata2_i) : opdata2_i;
                        neg_quo_d = signed_div_i && (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                        neg_rem_d = signed_div_i && opdata1_i[WIDTH-1];
                    end
                end
            end

            S_BYZERO: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else begin
                    state_d  = S_END;
                    result_d = '0;
                end
            end

            S_ON: begin
                if (annul_i) begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                    cnt_d    = '0;
                end else if (cnt_q != CNT_W'(WIDTH)) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {neg_rem_q ? negate(rem_q) : rem_q,
                                neg_quo_q ? negate(quo_q) : quo_q};
                    ready_d  = 1'b1;
                    state_d  = S_END;
                end
            end

            S_END: begin
                // Held start_i keeps the result; no restart until it drops.
                if (start_i) begin
                    ready_d = 1'b1;
                end else begin
                    state_d  = S_FREE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d = S_FREE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            ready_o   <= 1'b0;
            result_o  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            ready_o   <= ready_d;
            result_o  <= result_d;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: a 32-bit and an 8-bit instance, directed cases
// plus randomized operands checked against a plain-arithmetic reference.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd;
    logic [31:0] op1, op2;
    logic        start32, start8, annul;
    logic [63:0] res32;
    logic        rdy32;
    logic [15:0] res8;
    logic        rdy8;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] res;
        int          k;
        int          lat;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t me;
    bit   prev32 = 1'b0;
    bit   prev8  = 1'b0;

    div_unit #(.WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(op1), .opdata2_i(op2),
        .start_i(start32), .annul_i(annul), .result_o(res32), .ready_o(rdy32)
    );

    div_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]),
        .start_i(start8), .annul_i(annul), .result_o(res8), .ready_o(rdy8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: truncating division on sign- or zero-extended integers.
    function automatic logic [63:0] model(input bit w8, input logic [31:0] a,
                                          input logic [31:0] b, input bit sgn);
        longint sa, sb, qv, rv;
        if (w8) begin
            if (b[7:0] == 8'd0) return 64'd0;
            if (sgn) begin
                sa = longint'($signed(a[7:0]));
                sb = longint'($signed(b[7:0]));
            end else begin
                sa = longint'(a[7:0]);
                sb = longint'(b[7:0]);
            end
        end else begin
            if (b == 32'd0) return 64'd0;
            if (sgn) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
            end else begin
                sa = longint'(a);
                sb = longint'(b);
            end
        end
        qv = sa / sb;
        rv = sa % sb;
        if (w8) return {48'd0, rv[7:0], qv[7:0]};
        return {rv[31:0], qv[31:0]};
    endfunction

    // Monitor: on each rising ready, pop and compare result and latency.
    always @(negedge clk) begin
        if (!rst) begin
            if (rdy32 && !prev32) begin
                if (q32.size() == 0) begin
                    check("unexpected_ready32", 64'd1, 64'd0);
                end else begin
                    me = q32.pop_front();
                    check("result32", res32, me.res);
                    check("latency32", 64'(cyc - me.k), 64'(me.lat));
                end
            end
            if (rdy8 && !prev8) begin
                if (q8.size() == 0) begin
                    check("unexpected_ready8", 64'd1, 64'd0);
                end else begin
                    me = q8.pop_front();
                    check("result8", {48'd0, res8}, me.res);
                    check("latency8", 64'(cyc - me.k), 64'(me.lat));
                end
            end
        end
        prev32 = rdy32;
        prev8  = rdy8;
    end

    task automatic do_div(input bit w8, input logic [31:0] a, input logic [31:0] b,
                          input bit sgn, input int hold);
        exp_t        e;
        logic [63:0] r;
        bit          zero, seen;
        @(negedge clk);
        op1 = a;
        op2 = b;
        sd  = sgn;
        r    = model(w8, a, b, sgn);
        zero = w8 ? (b[7:0] == 8'd0) : (b == 32'd0);
        e.res = r;
        e.k   = cyc + 1;
        e.lat = zero ? 2 : (w8 ? 9 : 33);
        if (w8) begin q8.push_back(e);  start8  = 1'b1; end
        else    begin q32.push_back(e); start32 = 1'b1; end
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            // Operands may change once accepted; the result must not.
            op1 = $urandom;
            op2 = $urandom;
            sd  = 1'($urandom);
            if (w8 ? rdy8 : rdy32) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("ready_timeout", 64'd0, 64'd1);
            start8  = 1'b0;
            start32 = 1'b0;
            return;
        end
        for (int n = 0; n < hold; n++) begin
            @(negedge clk);
            check("hold_ready", 64'(w8 ? rdy8 : rdy32), 64'd1);
            check("hold_result", w8 ? {48'd0, res8} : res32, r);
        end
        start8  = 1'b0;
        start32 = 1'b0;
        @(negedge clk);
        check("drop_ready", 64'(w8 ? rdy8 : rdy32), 64'd0);
        check("drop_result", w8 ? {48'd0, res8} : res32, 64'd0);
    endtask

    initial begin
        bit          any;
        logic [31:0] a, b;
        rst = 1'b1; sd = 1'b0; op1 = '0; op2 = '0;
        start32 = 1'b0; start8 = 1'b0; annul = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready32", 64'(rdy32), 64'd0);
        check("reset_result32", res32, 64'd0);
        check("reset_ready8", 64'(rdy8), 64'd0);
        rst = 1'b0;

        do_div(1'b0, 32'd100, 32'd7, 1'b0, 1);
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_div(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_div(1'b0, 32'd55, 32'd0, 1'b0, 2);

        // Flush at cnt=10: no result may appear.
        @(negedge clk);
        op1 = 32'd1000; op2 = 32'd3; sd = 1'b0; start32 = 1'b1;
        repeat (11) @(negedge clk);
        annul = 1'b1; start32 = 1'b0;
        @(negedge clk);
        annul = 1'b0;
        any = 1'b0;
        repeat (40) begin @(negedge clk); any |= rdy32; end
        check("annul_no_ready", 64'(any), 64'd0);
        do_div(1'b0, 32'd9, 32'd3, 1'b0, 0);

        // Reset at cnt=20 discards the division.
        @(negedge clk);
        op1 = 32'd5000; op2 = 32'd7; sd = 1'b0; start32 = 1'b1;
        repeat (21) @(negedge clk);
        rst = 1'b1; start32 = 1'b0;
        @(negedge clk);
        check("midreset_ready", 64'(rdy32), 64'd0);
        check("midreset_result", res32, 64'd0);
        rst = 1'b0;
        any = 1'b0;
        repeat (40) begin @(negedge clk); any |= rdy32; end
        check("midreset_no_ready", 64'(any), 64'd0);
        do_div(1'b0, 32'd12345, 32'd17, 1'b0, 5);

        do_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_div(1'b1, 32'd200, 32'd3, 1'b0, 1);
        do_div(1'b1, 32'h0000_009C, 32'd7, 1'b1, 0);
        do_div(1'b1, 32'd9, 32'd0, 1'b1, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'd1;
                2:       b = 32'hFFFF_FFFF;
                3:       b = 32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            a = ($urandom_range(0, 7) == 0) ? ((i % 4 == 0) ? 32'h80 : 32'h8000_0000) : $urandom;
            do_div((i % 4) == 0, a, b, 1'($urandom), int'($urandom_range(0, 3)));
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(q32.size() + q8.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
